// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: default widths, write-back
// control bit positions, payload layout and occupancy states.
package mem_wb_pkg;

  localparam int CTL_W_DEFAULT  = 2;
  localparam int DATA_W_DEFAULT = 32;
  localparam int RD_W_DEFAULT   = 5;

  localparam int CTL_REGWRITE = 1;
  localparam int CTL_MEMTOREG = 0;

  typedef struct packed {
    logic [CTL_W_DEFAULT-1:0]  ctlwb;
    logic [DATA_W_DEFAULT-1:0] rdata;
    logic [DATA_W_DEFAULT-1:0] alu_out;
    logic [RD_W_DEFAULT-1:0]   rd;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_slot.sv
// One payload register with a load enable plus a valid bit; both are zeroed by
// the synchronous active-low reset.
module mem_wb_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         valid_in,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_in;
    if (load) data_d = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with valid/ready handshake, stall and flush.
// Define MEM_WB_SKID_EN for the two-entry skid build with a registered MEM_ready.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int CTL_W  = CTL_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_W   = RD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              MEM_valid,
  output logic              MEM_ready,
  input  logic [CTL_W-1:0]  MEM_ctlwb,
  input  logic [DATA_W-1:0] MEM_rdata,
  input  logic [DATA_W-1:0] MEM_alu_out,
  input  logic [RD_W-1:0]   MEM_rd,
  output logic              WB_valid,
  input  logic              WB_ready,
  output logic [CTL_W-1:0]  WB_ctlwb,
  output logic [DATA_W-1:0] WB_rdata,
  output logic [DATA_W-1:0] WB_alu_out,
  output logic [RD_W-1:0]   WB_rd,
  output logic [DATA_W-1:0] WB_wdata
);

  localparam int PW = CTL_W + 2 * DATA_W + RD_W;

  // Handshake: an entry moves on a rising edge when valid && ready are both
  // high in the preceding cycle; flush overrides every transfer in that cycle.
  state_e          state_d, state_q;
  logic            mem_ready, accept, consume;
  logic            out_load, out_valid;
  logic [PW-1:0]   mem_payload, out_din, out_dout;
  logic [CTL_W-1:0] out_ctl;

  assign mem_payload = {MEM_ctlwb, MEM_rdata, MEM_alu_out, MEM_rd};
  assign accept      = MEM_valid && mem_ready;
  assign consume     = out_valid && WB_ready;

`ifdef MEM_WB_SKID_EN
  logic          skid_load, skid_valid;
  logic [PW-1:0] skid_dout;
  logic          mem_ready_d, mem_ready_q;

  mem_wb_slot #(.W(PW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .valid_in (state_d == TWO),
    .din      (mem_payload),
    .valid    (skid_valid),
    .dout     (skid_dout)
  );

  // The output refills from the skid whenever the skid holds the older entry.
  assign out_din     = skid_valid ? skid_dout : mem_payload;
  assign mem_ready_d = (state_d != TWO);
  assign mem_ready   = mem_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) mem_ready_q <= 1'b1;
    else        mem_ready_q <= mem_ready_d;
  end
`else
  assign out_din   = mem_payload;
  assign mem_ready = !out_valid || WB_ready;
`endif

  always_comb begin
    state_d  = state_q;
    out_load = 1'b0;
`ifdef MEM_WB_SKID_EN
    skid_load = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            out_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_load = 1'b1;
`ifdef MEM_WB_SKID_EN
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
`endif
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
`ifdef MEM_WB_SKID_EN
        TWO: begin
          if (consume) begin
            state_d  = ONE;
            out_load = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  mem_wb_slot #(.W(PW)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (out_load),
    .valid_in (state_d != EMPTY),
    .din      (out_din),
    .valid    (out_valid),
    .dout     (out_dout)
  );

  assign {out_ctl, WB_rdata, WB_alu_out, WB_rd} = out_dout;
  assign MEM_ready = mem_ready;
  assign WB_valid  = out_valid;
  // An empty stage presents zero control so the register file never writes.
  assign WB_ctlwb  = out_valid ? out_ctl : '0;
  assign WB_wdata  = WB_ctlwb[CTL_MEMTOREG] ? WB_rdata : WB_alu_out;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe; handles both builds (MEM_WB_SKID_EN defined or not).
module tb_mem_wb_pipe;
  import mem_wb_pkg::*;

  localparam int PW = $bits(payload_t);

  logic        clk = 1'b0;
  logic        rst_n, flush, MEM_valid, MEM_ready, WB_valid, WB_ready;
  logic [1:0]  MEM_ctlwb, WB_ctlwb;
  logic [31:0] MEM_rdata, MEM_alu_out, WB_rdata, WB_alu_out, WB_wdata;
  logic [4:0]  MEM_rd, WB_rd;

  logic [PW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;

  mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .MEM_valid(MEM_valid), .MEM_ready(MEM_ready), .MEM_ctlwb(MEM_ctlwb),
    .MEM_rdata(MEM_rdata), .MEM_alu_out(MEM_alu_out), .MEM_rd(MEM_rd),
    .WB_valid(WB_valid), .WB_ready(WB_ready), .WB_ctlwb(WB_ctlwb),
    .WB_rdata(WB_rdata), .WB_alu_out(WB_alu_out), .WB_rd(WB_rd), .WB_wdata(WB_wdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [1:0] c, input logic [31:0] rdat,
                            input logic [31:0] alu, input logic [4:0] rd,
                            output int waits);
    payload_t p;
    bit done;
    p = '{ctlwb: c, rdata: rdat, alu_out: alu, rd: rd};
    MEM_valid = 1'b1; MEM_ctlwb = c; MEM_rdata = rdat; MEM_alu_out = alu; MEM_rd = rd;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (MEM_ready) begin
        exp_q.push_back(p);
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    if (!done) check("push_timeout", 64'(waits), 64'(0));
    MEM_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [31:0] rdat,
                      input logic [31:0] alu, input logic [4:0] rd);
    int w;
    push_entry(c, rdat, alu, rd, w);
  endtask

  // scoreboard monitor: compares every consumed output against the queue head
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else if (WB_valid && WB_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_output_rd", 64'(WB_rd), 64'hffff);
      end else begin
        payload_t e;
        e = exp_q.pop_front();
        check("out_ctlwb", 64'(WB_ctlwb), 64'(e.ctlwb));
        check("out_rd", 64'(WB_rd), 64'(e.rd));
        check("out_rdata", 64'(WB_rdata), 64'(e.rdata));
        check("out_alu", 64'(WB_alu_out), 64'(e.alu_out));
        check("out_wdata", 64'(WB_wdata), 64'(e.ctlwb[0] ? e.rdata : e.alu_out));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(WB_valid), 64'(0));
    check({tag, "_ctlwb"}, 64'(WB_ctlwb), 64'(0));
    check({tag, "_rdata"}, 64'(WB_rdata), 64'(0));
    check({tag, "_alu"},   64'(WB_alu_out), 64'(0));
    check({tag, "_rd"},    64'(WB_rd), 64'(0));
    check({tag, "_wdata"}, 64'(WB_wdata), 64'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int w;
    int out_base;
    rst_n = 1'b0; flush = 1'b0; MEM_valid = 1'b0; WB_ready = 1'b0;
    MEM_ctlwb = '0; MEM_rdata = '0; MEM_alu_out = '0; MEM_rd = '0;

    // reset held two cycles
    idle(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("reset_mem_ready", 64'(MEM_ready), 64'(1));

    // single entry: visible right after the accepting edge
    WB_ready = 1'b1;
    push(2'b11, 32'hDEADBEEF, 32'h10, 5'd5);
    check("single_valid", 64'(WB_valid), 64'(1));
    check("single_wdata", 64'(WB_wdata), 64'hDEADBEEF);
    check("single_ctlwb", 64'(WB_ctlwb), 64'(2'b11));
    idle(2);

    // back-to-back stream of 8 with WB_ready high
    out_base = n_out;
    for (int i = 1; i <= 8; i++) begin
      push_entry(2'(i % 4), 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i), w);
      check("stream_no_stall", 64'(w), 64'(0));
      check("stream_valid", 64'(WB_valid), 64'(1));
      check("stream_rd", 64'(WB_rd), 64'(i));
    end
    idle(3);
    check("stream_count", 64'(n_out - out_base), 64'(8));

    // backpressure: WB_ready low for 4 cycles mid-stream
    out_base = n_out;
    WB_ready = 1'b0;
    push(2'b10, 32'h0, 32'h20, 5'd20);
`ifdef MEM_WB_SKID_EN
    check("bp_ready_after_1", 64'(MEM_ready), 64'(1));
    push(2'b10, 32'h0, 32'h21, 5'd21);
    check("bp_ready_after_2", 64'(MEM_ready), 64'(0));
    fork
      push(2'b11, 32'h22, 32'h0, 5'd22);
      begin idle(2); WB_ready = 1'b1; end
    join
`else
    check("bp_ready_after_1", 64'(MEM_ready), 64'(0));
    fork
      push(2'b10, 32'h0, 32'h21, 5'd21);
      begin idle(3); WB_ready = 1'b1; end
    join
    push(2'b11, 32'h22, 32'h0, 5'd22);
`endif
    push(2'b10, 32'h0, 32'h23, 5'd23);
    push(2'b01, 32'h24, 32'h0, 5'd24);
    idle(4);
    check("bp_count", 64'(n_out - out_base), 64'(5));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // flush while an entry is offered
    WB_ready = 1'b0;
    push(2'b10, 32'h0, 32'h30, 5'd30);
`ifdef MEM_WB_SKID_EN
    push(2'b10, 32'h0, 32'h31, 5'd31);
    check("flush_pre_ready", 64'(MEM_ready), 64'(0));
`endif
    flush = 1'b1; MEM_valid = 1'b1;
    MEM_ctlwb = 2'b11; MEM_rdata = 32'hBAD; MEM_alu_out = 32'hBAD; MEM_rd = 5'd31;
    tick();
    flush = 1'b0; MEM_valid = 1'b0;
    check("flush_valid", 64'(WB_valid), 64'(0));
    check("flush_ctlwb", 64'(WB_ctlwb), 64'(0));
    check("flush_ready", 64'(MEM_ready), 64'(1));
    out_base = n_out;
    WB_ready = 1'b1;
    idle(3);
    check("flush_nothing_out", 64'(n_out - out_base), 64'(0));

    // write-data mux select
    push(2'b10, 32'hAAAA, 32'h1234, 5'd7);
    check("mux_alu", 64'(WB_wdata), 64'h1234);
    push(2'b01, 32'h5678, 32'hBBBB, 5'd8);
    check("mux_load", 64'(WB_wdata), 64'h5678);
    idle(2);

    // synchronous reset mid-stream
    WB_ready = 1'b0;
    push(2'b11, 32'h40, 32'h41, 5'd12);
`ifdef MEM_WB_SKID_EN
    push(2'b11, 32'h42, 32'h43, 5'd13);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pre_edge_valid", 64'(WB_valid), 64'(1));
    check("rst_pre_edge_rd", 64'(WB_rd), 64'(12));
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    #1;
    check("midrst_ready", 64'(MEM_ready), 64'(1));
    out_base = n_out;
    WB_ready = 1'b1;
    idle(3);
    check("midrst_nothing_out", 64'(n_out - out_base), 64'(0));

    // traffic resumes normally
    push(2'b10, 32'h0, 32'h55, 5'd9);
    idle(3);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
